// File: rtl/hwag_tooth_sync_if.sv
// Tooth-sync signal bundle: edge/period inputs from the capture stage and
// tooth/sync outputs toward the angle/interrupt logic.
interface hwag_tooth_sync_if #(
  parameter int PW = 24,
  parameter int TW = 8
);
  logic          ena;
  logic          edge_stb;
  logic [PW-1:0] period;
  logic          pcnt_ovf;
  logic [3:0]    gap_k;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] prev_per;
  logic          sync;
  logic          tooth_stb;
  logic          gap_stb;
  logic          sync_err;

  modport master (
    output ena, edge_stb, period, pcnt_ovf, gap_k,
    input  tcnt, prev_per, sync, tooth_stb, gap_stb, sync_err
  );

  modport slave (
    input  ena, edge_stb, period, pcnt_ovf, gap_k,
    output tcnt, prev_per, sync, tooth_stb, gap_stb, sync_err
  );
endinterface

// File: rtl/hwag_tooth_sync.sv
// Missing-tooth gap finder and tooth counter; declares crank sync after two
// gaps spaced exactly TEETH edges apart.
module hwag_tooth_sync #(
  parameter int PW    = 24,
  parameter int TW    = 8,
  parameter int TEETH = 58
) (
  input  logic              clk,
  input  logic              rst,
  hwag_tooth_sync_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT1  = 3'd1,
    SEARCH = 3'd2,
    CHECK  = 3'd3,
    SYNC   = 3'd4
  } state_t;

  localparam logic [TW-1:0] LAST_TOOTH = TW'(TEETH - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic [PW-1:0] prev_per_reg, prev_per_next;
  logic          sync_reg, sync_next;
  logic          tooth_stb_reg, tooth_stb_next;
  logic          gap_stb_reg, gap_stb_next;
  logic          sync_err_reg, sync_err_next;

  // Threshold kept at PW+4 bits so prev_per*15 cannot wrap.
  logic [PW+3:0] thr_prod;
  logic [PW+3:0] thr;
  logic [PW+3:0] period_ext;
  logic          is_gap;

  assign thr_prod   = {4'b0000, prev_per_reg} * {{PW{1'b0}}, bus.gap_k};
  assign thr        = thr_prod >> 2;
  assign period_ext = {4'b0000, bus.period};
  assign is_gap     = (bus.gap_k != 4'd0) && (period_ext >= thr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      tcnt_reg      <= '0;
      prev_per_reg  <= '0;
      sync_reg      <= 1'b0;
      tooth_stb_reg <= 1'b0;
      gap_stb_reg   <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tcnt_reg      <= tcnt_next;
      prev_per_reg  <= prev_per_next;
      sync_reg      <= sync_next;
      tooth_stb_reg <= tooth_stb_next;
      gap_stb_reg   <= gap_stb_next;
      sync_err_reg  <= sync_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tcnt_next      = tcnt_reg;
    prev_per_next  = prev_per_reg;
    tooth_stb_next = 1'b0;
    gap_stb_next   = 1'b0;
    sync_err_next  = 1'b0;

    if (!bus.ena) begin
      state_next    = IDLE;
      tcnt_next     = '0;
      prev_per_next = '0;
    end else if (state_reg == IDLE) begin
      state_next = WAIT1;
    end else if (bus.pcnt_ovf) begin
      // Stall: any coincident edge is dropped.
      state_next    = WAIT1;
      tcnt_next     = '0;
      prev_per_next = '0;
      sync_err_next = (state_reg == SYNC);
    end else if (bus.edge_stb) begin
      prev_per_next  = bus.period;
      tooth_stb_next = 1'b1;
      case (state_reg)
        WAIT1: begin
          state_next = SEARCH;
        end
        SEARCH: begin
          if (is_gap) begin
            tcnt_next    = '0;
            gap_stb_next = 1'b1;
            state_next   = CHECK;
          end
        end
        CHECK, SYNC: begin
          if (tcnt_reg == LAST_TOOTH) begin
            tcnt_next = '0;
            if (is_gap) begin
              gap_stb_next = 1'b1;
              state_next   = SYNC;
            end else begin
              sync_err_next = (state_reg == SYNC);
              state_next    = SEARCH;
            end
          end else if (is_gap) begin
            // Early gap becomes the new candidate.
            tcnt_next     = '0;
            gap_stb_next  = 1'b1;
            sync_err_next = (state_reg == SYNC);
            state_next    = CHECK;
          end else begin
            tcnt_next = tcnt_reg + TW'(1);
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    sync_next = (state_next == SYNC);
  end

  assign bus.tcnt      = tcnt_reg;
  assign bus.prev_per  = prev_per_reg;
  assign bus.sync      = sync_reg;
  assign bus.tooth_stb = tooth_stb_reg;
  assign bus.gap_stb   = gap_stb_reg;
  assign bus.sync_err  = sync_err_reg;

endmodule

// File: tb/tb_hwag_tooth_sync.sv
// Scoreboard bench for hwag_tooth_sync: stimulus pushes expected strobe
// responses, a negedge monitor pops and compares them.
module tb_hwag_tooth_sync;

  logic clk;
  logic rst;

  hwag_tooth_sync_if #(.PW(24), .TW(8)) bus ();

  hwag_tooth_sync #(.PW(24), .TW(8), .TEETH(58)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        tooth;
    logic        gap;
    logic        err;
    logic        sync;
    logic [7:0]  tcnt;
    logic [23:0] prev;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  exp_t mon_act;
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (bus.tooth_stb || bus.gap_stb || bus.sync_err) begin
      checks++;
      mon_act = '{bus.tooth_stb, bus.gap_stb, bus.sync_err, bus.sync, bus.tcnt, bus.prev_per};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe t=%0t got tooth=%0b gap=%0b err=%0b sync=%0b tcnt=%0d prev=%0d",
                 $time, mon_act.tooth, mon_act.gap, mon_act.err, mon_act.sync, mon_act.tcnt, mon_act.prev);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL edge_resp t=%0t got tooth=%0b gap=%0b err=%0b sync=%0b tcnt=%0d prev=%0d want tooth=%0b gap=%0b err=%0b sync=%0b tcnt=%0d prev=%0d",
                   $time, mon_act.tooth, mon_act.gap, mon_act.err, mon_act.sync, mon_act.tcnt, mon_act.prev,
                   mon_exp.tooth, mon_exp.gap, mon_exp.err, mon_exp.sync, mon_exp.tcnt, mon_exp.prev);
        end else begin
          $display("edge t=%0t tooth=%0b gap=%0b err=%0b sync=%0b tcnt=%0d prev=%0d",
                   $time, mon_act.tooth, mon_act.gap, mon_act.err, mon_act.sync, mon_act.tcnt, mon_act.prev);
        end
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic send_edge(input logic [23:0] p, input int et, input logic es,
                           input logic eg, input logic ee);
    exp_q.push_back('{1'b1, eg, ee, es, 8'(et), p});
    bus.edge_stb = 1'b1;
    bus.period   = p;
    @(posedge clk); #1;
    bus.edge_stb = 1'b0;
  endtask

  task automatic send_ovf_edge(input logic [23:0] p, input logic ee);
    exp_q.push_back('{1'b0, 1'b0, ee, 1'b0, 8'd0, 24'd0});
    bus.edge_stb = 1'b1;
    bus.pcnt_ovf = 1'b1;
    bus.period   = p;
    @(posedge clk); #1;
    bus.edge_stb = 1'b0;
    bus.pcnt_ovf = 1'b0;
  endtask

  task automatic check_outs(input string name, input logic [7:0] et,
                            input logic [23:0] ep, input logic es);
    checks++;
    if (bus.tcnt !== et || bus.prev_per !== ep || bus.sync !== es ||
        bus.tooth_stb !== 1'b0 || bus.gap_stb !== 1'b0 || bus.sync_err !== 1'b0) begin
      errors++;
      $display("FAIL %s got tcnt=%0d prev=%0d sync=%0b strobes=%0b%0b%0b want tcnt=%0d prev=%0d sync=%0b strobes=000",
               name, bus.tcnt, bus.prev_per, bus.sync, bus.tooth_stb, bus.gap_stb, bus.sync_err, et, ep, es);
    end else begin
      $display("check %s tcnt=%0d prev=%0d sync=%0b", name, bus.tcnt, bus.prev_per, bus.sync);
    end
  endtask

  // From WAIT1: 10 short, gap, 57 short, gap -> SYNC with tcnt=0.
  task automatic acquire();
    for (int i = 0; i < 10; i++) send_edge(24'd1000, 0, 1'b0, 1'b0, 1'b0);
    send_edge(24'd3000, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 57; i++) send_edge(24'd1000, i, 1'b0, 1'b0, 1'b0);
    send_edge(24'd3000, 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic run_sync(input int n);
    for (int i = 1; i <= n; i++) send_edge(24'd1000, i, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst          = 1'b0;
    bus.ena      = 1'b0;
    bus.edge_stb = 1'b0;
    bus.period   = '0;
    bus.pcnt_ovf = 1'b0;
    bus.gap_k    = 4'd8;
    #1;
    check_outs("reset_state", 8'd0, 24'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b1;
    bus.ena = 1'b1;
    @(posedge clk); #1;  // IDLE -> WAIT1

    // Acquire, then a full revolution of teeth.
    acquire();
    run_sync(57);
    // Missing gap at tcnt=57 in SYNC.
    send_edge(24'd1000, 0, 1'b0, 1'b0, 1'b1);

    // Threshold boundary from SEARCH with gap_k=8.
    send_edge(24'd1999, 0, 1'b0, 1'b0, 1'b0);
    send_edge(24'd1000, 0, 1'b0, 1'b0, 1'b0);
    send_edge(24'd2000, 0, 1'b0, 1'b1, 1'b0);
    // Detection off: nothing is a gap.
    bus.gap_k = 4'd0;
    send_edge(24'd1000, 1, 1'b0, 1'b0, 1'b0);
    send_edge(24'd5000, 2, 1'b0, 1'b0, 1'b0);
    send_edge(24'd1000, 3, 1'b0, 1'b0, 1'b0);
    send_edge(24'hFFFFFF, 4, 1'b0, 1'b0, 1'b0);
    send_edge(24'd1000, 5, 1'b0, 1'b0, 1'b0);
    send_edge(24'd2000, 6, 1'b0, 1'b0, 1'b0);
    bus.gap_k = 4'd8;

    // Disable in CHECK.
    bus.ena = 1'b0;
    @(posedge clk); #1;
    check_outs("ena_off", 8'd0, 24'd0, 1'b0);
    bus.ena = 1'b1;
    @(posedge clk); #1;
    acquire();

    // Early gap in SYNC at tcnt=39, then confirm CHECK re-syncs.
    run_sync(39);
    send_edge(24'd3000, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 57; i++) send_edge(24'd1000, i, 1'b0, 1'b0, 1'b0);
    send_edge(24'd3000, 0, 1'b1, 1'b1, 1'b0);

    // Overflow together with an edge in SYNC.
    run_sync(10);
    send_ovf_edge(24'd1000, 1'b1);
    acquire();
    run_sync(30);

    // Async reset mid-SYNC at tcnt=30, away from any clock edge.
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_outs("async_reset", 8'd0, 24'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;  // IDLE -> WAIT1
    send_edge(24'd1000, 0, 1'b0, 1'b0, 1'b0);
    send_edge(24'd3000, 0, 1'b0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses got pending=%0d want pending=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
